// File: rtl/key_lut_cam.sv
// key_lut_cam: small fully associative key->data table with a valid/ready lookup port.
// Writes install or update entries (victim replacement when full).
// Lookups return a registered response one cycle after acceptance.
module key_lut_cam #(
  parameter int unsigned N_KEY       = 4,
  parameter int unsigned KEY_LEN     = 8,
  parameter int unsigned DATA_LEN    = 16,
  parameter bit          HAS_DEFAULT = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [KEY_LEN-1:0]               wr_key,
  input  logic [DATA_LEN-1:0]              wr_data,
  input  logic                             flush,
  input  logic                             lk_valid,
  output logic                             lk_ready,
  input  logic [KEY_LEN-1:0]               lk_key,
  input  logic [DATA_LEN-1:0]              default_out,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_LEN-1:0]              rsp_data,
  output logic                             rsp_hit,
  output logic [$clog2(N_KEY)-1:0]         rsp_idx,
  output logic [$clog2(N_KEY+1)-1:0]       count
);

  localparam int unsigned IDX_W = $clog2(N_KEY);
  localparam int unsigned CNT_W = $clog2(N_KEY + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_KEY - 1);

  logic [N_KEY-1:0]    valid;
  logic [KEY_LEN-1:0]  keys [N_KEY];
  logic [DATA_LEN-1:0] data [N_KEY];
  logic [IDX_W-1:0]    victim;

  logic             lk_hit;
  logic [IDX_W-1:0] lk_idx;
  logic             wr_hit;
  logic [IDX_W-1:0] wr_hit_idx;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             wr_do;
  logic [IDX_W-1:0] wr_idx;
  logic             lk_accept;

  // Search the table for the lookup key, the write key and the lowest free slot.
  always_comb begin
    lk_hit     = 1'b0;
    lk_idx     = '0;
    wr_hit     = 1'b0;
    wr_hit_idx = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < int'(N_KEY); i++) begin
      if (!lk_hit && valid[i] && (keys[i] == lk_key)) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
      if (!wr_hit && valid[i] && (keys[i] == wr_key)) begin
        wr_hit     = 1'b1;
        wr_hit_idx = IDX_W'(i);
      end
      if (!free_found && !valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Choose the entry a write lands in: existing key, else lowest free slot, else victim.
  always_comb begin
    wr_do  = wr_en && !flush;
    wr_idx = victim;
    if (wr_hit) begin
      wr_idx = wr_hit_idx;
    end else if (free_found) begin
      wr_idx = free_idx;
    end
  end

  assign lk_ready  = !rsp_valid || rsp_ready;
  assign lk_accept = lk_valid && lk_ready;

  // Key and data storage; contents are only meaningful where the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_do) begin
      keys[wr_idx] <= wr_key;
      data[wr_idx] <= wr_data;
    end
  end

  // Valid bits, occupancy count and round-robin victim pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= '0;
      count  <= '0;
      victim <= '0;
    end else if (flush) begin
      valid  <= '0;
      count  <= '0;
      victim <= '0;
    end else if (wr_en && !wr_hit) begin
      valid[wr_idx] <= 1'b1;
      if (free_found) begin
        count <= count + CNT_W'(1);
      end else begin
        victim <= (victim == LAST_IDX) ? '0 : victim + IDX_W'(1);
      end
    end
  end

  // Response register: captures pre-edge lookup result, holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_idx   <= '0;
      rsp_data  <= '0;
    end else if (lk_accept) begin
      rsp_valid <= 1'b1;
      rsp_hit   <= lk_hit;
      rsp_idx   <= lk_hit ? lk_idx : '0;
      if (lk_hit) begin
        rsp_data <= data[lk_idx];
      end else begin
        rsp_data <= HAS_DEFAULT ? default_out : '0;
      end
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
